// File: rtl/matrix_unloader.sv
// matrix_unloader: holds one matrix and streams it as a dims header then row-major element nibbles.
// Define MATRIX_UNLOADER_CHECKSUM_EN to append a mod-16 checksum nibble after the data.
module matrix_unloader #(
  parameter int MAX_DIM = 4,
  parameter int ELEM_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dim_we,
  input  logic [3:0]        rows_in,
  input  logic [3:0]        cols_in,
  input  logic              wr_en,
  input  logic [3:0]        wr_row,
  input  logic [3:0]        wr_col,
  input  logic [ELEM_W-1:0] wr_data,
  input  logic              start,
  input  logic              ready,
  output logic [3:0]        data_out,
  output logic              ctrl_out,
  output logic              valid_out,
  output logic              busy,
  output logic              done
);
  localparam int NIB = ELEM_W / 4;
  localparam int NW = NIB > 1 ? $clog2(NIB) : 1;
  localparam int DEPTH = MAX_DIM * MAX_DIM;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [3:0] MD = 4'(MAX_DIM);
`ifdef MATRIX_UNLOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR_R, HDR_C, DATA, CSUM, FIN} state_t;
  localparam state_t POST = CSUM;
`else
  typedef enum logic [2:0] {IDLE, HDR_R, HDR_C, DATA, FIN} state_t;
  localparam state_t POST = FIN;
`endif
  state_t state_q, state_d;
  logic [3:0] rows_q, rows_d, cols_q, cols_d, row_q, row_d, col_q, col_d;
  logic [NW-1:0] nib_q, nib_d, nib_rev;
  logic [ELEM_W-1:0] mem_q [DEPTH];
  logic [ELEM_W-1:0] elem;
  logic [7:0] wa, ra;
  logic [3:0] nib_val;
  logic xfer, wr_ok, last_nib, last_col, last_row;
  assign xfer = valid_out && ready;
  assign wr_ok = wr_en && state_q == IDLE && wr_row < MD && wr_col < MD;
  assign wa = {4'd0, wr_row} * {4'd0, MD} + {4'd0, wr_col};
  assign ra = {4'd0, row_q} * {4'd0, MD} + {4'd0, col_q};
  assign elem = mem_q[ra[AW-1:0]];
  assign nib_rev = NW'(NIB - 1) - nib_q;
  assign nib_val = 4'(elem >> {nib_rev, 2'b00});
  assign last_nib = nib_q == NW'(NIB - 1);
  assign last_col = col_q == cols_q - 4'd1;
  assign last_row = row_q == rows_q - 4'd1;
  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (wr_ok) mem_q[wa[AW-1:0]] <= wr_data;
  end
`ifdef MATRIX_UNLOADER_CHECKSUM_EN
  logic [3:0] csum_q, csum_d;
  assign csum_d = (state_q == IDLE && start) ? 4'd0 : xfer ? csum_q + data_out : csum_q;
  always_ff @(posedge CLK) begin
    if (RST) csum_q <= 4'd0;
    else csum_q <= csum_d;
  end
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      rows_q <= 4'd0;
      cols_q <= 4'd0;
      row_q <= 4'd0;
      col_q <= 4'd0;
      nib_q <= '0;
    end else begin
      state_q <= state_d;
      rows_q <= rows_d;
      cols_q <= cols_d;
      row_q <= row_d;
      col_q <= col_d;
      nib_q <= nib_d;
    end
  end
  always_comb begin
    state_d = state_q;
    rows_d = rows_q;
    cols_d = cols_q;
    row_d = row_q;
    col_d = col_q;
    nib_d = nib_q;
    case (state_q)
      IDLE: begin
        if (dim_we) begin
          rows_d = rows_in > MD ? MD : rows_in;
          cols_d = cols_in > MD ? MD : cols_in;
        end
        if (start) begin
          state_d = HDR_R;
          row_d = 4'd0;
          col_d = 4'd0;
          nib_d = '0;
        end
      end
      HDR_R: if (xfer) state_d = HDR_C;
      HDR_C: if (xfer) state_d = (rows_q == 4'd0 || cols_q == 4'd0) ? POST : DATA;
      DATA: if (xfer) begin
        nib_d = last_nib ? '0 : nib_q + 1'b1;
        if (last_nib) begin
          col_d = last_col ? 4'd0 : col_q + 4'd1;
          row_d = last_col ? row_q + 4'd1 : row_q;
          if (last_col && last_row) state_d = POST;
        end
      end
`ifdef MATRIX_UNLOADER_CHECKSUM_EN
      CSUM: if (xfer) state_d = FIN;
`endif
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    valid_out = state_q == HDR_R || state_q == HDR_C || state_q == DATA;
    ctrl_out = state_q == HDR_R || state_q == HDR_C;
    data_out = state_q == HDR_R ? rows_q : state_q == HDR_C ? cols_q : state_q == DATA ? nib_val : 4'd0;
`ifdef MATRIX_UNLOADER_CHECKSUM_EN
    valid_out = valid_out || state_q == CSUM;
    ctrl_out = ctrl_out || state_q == CSUM;
    data_out = state_q == CSUM ? csum_q : data_out;
`endif
    busy = valid_out;
    done = state_q == FIN;
  end
endmodule
